// File: rtl/cad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cad_pkg
//  Description : Shared constants and types for the result-collector path.
//  Revision    : 1.0
// ============================================================================
package cad_pkg;

  // Number of producer channels merged onto the shared result bus.
  localparam int NUM_CH       = 4;
  // Default width of a result code.
  localparam int SIZE_DEFAULT = 5;
  // Width of the source tag (log2 of NUM_CH).
  localparam int SRC_W        = 2;

  // Collector state: IDLE means the bus is empty, HOLD means res is presented.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick4
//  Description : Combinational 4-way round-robin picker. Searches the valid
//                vector starting at ptr_i and wrapping, returning a one-hot
//                grant, its index and an any-valid flag.
//  Revision    : 1.0
// ============================================================================
module rr_pick4
  import cad_pkg::*;
(
  input  logic [NUM_CH-1:0] vld_i,
  input  logic [SRC_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [SRC_W-1:0]  idx_o,
  output logic              any_o
);

  // Priority search from ptr_i upward; the first valid hit wins.
  always_comb begin
    logic             found;
    logic [SRC_W-1:0] k;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    k       = '0;
    for (int o = 0; o < NUM_CH; o++) begin
      k = ptr_i + o[SRC_W-1:0];
      if (!found && vld_i[k]) begin
        found      = 1'b1;
        idx_o      = k;
        grant_o[k] = 1'b1;
      end
    end
    any_o = found;
  end

endmodule
`default_nettype wire

// File: rtl/res_collector.sv
`default_nettype none
// ============================================================================
//  Module      : res_collector
//  Description : Merges result codes from four producers onto one registered
//                res bus with enable qualifier and source tag. Round-robin
//                arbitration, per-channel valid/ready, downstream ack.
//  Revision    : 1.0
// ============================================================================
module res_collector
  import cad_pkg::*;
#(
  parameter int size = SIZE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [size-1:0]  i1,
  input  logic [size-1:0]  i2,
  input  logic [size-1:0]  i3,
  input  logic [size-1:0]  i4,
  input  logic             v1,
  input  logic             v2,
  input  logic             v3,
  input  logic             v4,
  output logic             rdy1,
  output logic             rdy2,
  output logic             rdy3,
  output logic             rdy4,
  output logic [size-1:0]  res,
  output logic             enable,
  output logic [SRC_W-1:0] src,
  input  logic             ack
);

  state_e            state_q;
  logic [SRC_W-1:0]  ptr_q;
  logic [size-1:0]   res_q;
  logic [SRC_W-1:0]  src_q;
  logic              enable_q;

  logic [NUM_CH-1:0] w_vld;
  logic [NUM_CH-1:0] w_grant;
  logic [SRC_W-1:0]  w_idx;
  logic              w_any;
  logic              w_window;
  logic [size-1:0]   w_in [NUM_CH];

  assign w_vld   = {v4, v3, v2, v1};
  assign w_in[0] = i1;
  assign w_in[1] = i2;
  assign w_in[2] = i3;
  assign w_in[3] = i4;

  rr_pick4 u_pick (
    .vld_i   (w_vld),
    .ptr_i   (ptr_q),
    .grant_o (w_grant),
    .idx_o   (w_idx),
    .any_o   (w_any)
  );

  // Grant window: bus empty, or current code being consumed this cycle.
  // Reset closes the window so no producer sees ready during reset.
  assign w_window = !rst && ((state_q == ST_IDLE) || ack);

  // Ready is the picker grant gated by the window (the ack -> rdy path).
  assign {rdy4, rdy3, rdy2, rdy1} = w_window ? w_grant : '0;

  // Collector FSM with registered bus outputs and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      res_q    <= '0;
      src_q    <= '0;
      enable_q <= 1'b0;
    end else if (w_window) begin
      if (w_any) begin
        // Transfer: capture the granted code; granted channel drops to
        // lowest priority.
        state_q  <= ST_HOLD;
        res_q    <= w_in[w_idx];
        src_q    <= w_idx;
        enable_q <= 1'b1;
        ptr_q    <= w_idx + 1'b1;
      end else if (state_q == ST_HOLD) begin
        // Consumed with nothing pending: drain to idle, bus back to zero.
        state_q  <= ST_IDLE;
        res_q    <= '0;
        src_q    <= '0;
        enable_q <= 1'b0;
      end
    end
  end

  assign res    = res_q;
  assign src    = src_q;
  assign enable = enable_q;

endmodule
`default_nettype wire

// File: tb/tb_res_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_res_collector
//  Description : Directed self-checking bench for res_collector.
//  Revision    : 1.0
// ============================================================================
module tb_res_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] i1, i2, i3, i4;
  logic       v1, v2, v3, v4;
  logic       rdy1, rdy2, rdy3, rdy4;
  logic [4:0] res;
  logic       enable;
  logic [1:0] src;
  logic       ack;

  int tests = 0;
  int fails = 0;

  res_collector #(.size(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .i1     (i1),
    .i2     (i2),
    .i3     (i3),
    .i4     (i4),
    .v1     (v1),
    .v2     (v2),
    .v3     (v3),
    .v4     (v4),
    .rdy1   (rdy1),
    .rdy2   (rdy2),
    .rdy3   (rdy3),
    .rdy4   (rdy4),
    .res    (res),
    .enable (enable),
    .src    (src),
    .ack    (ack)
  );

  always #5 clk = ~clk;

  wire [3:0] rdy = {rdy4, rdy3, rdy2, rdy1};

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setv(input logic [3:0] v);
    {v4, v3, v2, v1} = v;
  endtask

  initial begin
    // 1. Reset with all producers valid
    rst = 1'b1; ack = 1'b0;
    i1 = 5'd1; i2 = 5'd2; i3 = 5'd3; i4 = 5'd4;
    setv(4'b1111);
    #1;  chk("rst_rdy_a", rdy, 4'b0000);
    step(); chk("rst_rdy_b", rdy, 4'b0000);
    step();
    rst = 1'b0; setv(4'b0000);
    #1;
    chk("rst_res", res, 0);
    chk("rst_en",  enable, 0);
    chk("rst_src", src, 0);
    chk("rst_rdy_c", rdy, 4'b0000);

    // 2. Single transfer on channel 3, then hold with ack low
    i3 = 5'd3; setv(4'b0100);
    #1;  chk("single_rdy", rdy, 4'b0100);
    step(); setv(4'b0000);
    #1;
    chk("single_res", res, 3);
    chk("single_en",  enable, 1);
    chk("single_src", src, 2);
    chk("single_rdy_off", rdy, 4'b0000);
    for (int n = 0; n < 5; n++) begin
      step();
      chk("hold_res", res, 3);
      chk("hold_en",  enable, 1);
      chk("hold_src", src, 2);
      chk("hold_rdy", rdy, 4'b0000);
    end

    // 3. Round-robin with ack held; reset first so channel 1 leads
    rst = 1'b1; step(); rst = 1'b0;
    i1 = 5'd1; i2 = 5'd2; i3 = 5'd3; i4 = 5'd4;
    setv(4'b1111); ack = 1'b1;
    #1;  chk("rr_rdy0", rdy, 4'b0001);
    for (int n = 0; n < 6; n++) begin
      step();
      chk("rr_res", res, 32'(n % 4 + 1));
      chk("rr_src", src, 32'(n % 4));
      chk("rr_en",  enable, 1);
      chk("rr_rdy", rdy, 32'(1 << ((n + 1) % 4)));
    end

    // 4. Get res=7 on the bus, then drain to idle
    ack = 1'b0; setv(4'b0100); i3 = 5'd7;
    #1;  chk("drain_stall_rdy", rdy, 4'b0000);
    ack = 1'b1;
    #1;  chk("drain_grant", rdy, 4'b0100);
    step(); ack = 1'b0; setv(4'b0000);
    #1;
    chk("drain_res7", res, 7);
    chk("drain_src",  src, 2);
    step();
    chk("drain_hold", res, 7);
    chk("drain_hold_en", enable, 1);
    ack = 1'b1;
    #1;  chk("drain_rdy", rdy, 4'b0000);
    step();
    chk("idle_en",  enable, 0);
    chk("idle_res", res, 0);
    chk("idle_src", src, 0);
    step();
    chk("idle_ack_en",  enable, 0);
    chk("idle_ack_res", res, 0);
    chk("idle_ack_rdy", rdy, 4'b0000);
    ack = 1'b0;

    // 5. Reset while holding src=2 (pointer currently at channel 4)
    i3 = 5'd9; setv(4'b0100);
    #1;  chk("mid_grant", rdy, 4'b0100);
    step(); setv(4'b0000);
    #1;
    chk("mid_src", src, 2);
    chk("mid_res", res, 9);
    rst = 1'b1; setv(4'b1111); ack = 1'b1;
    #1;  chk("mid_rst_rdy", rdy, 4'b0000);
    step(); rst = 1'b0; ack = 1'b0;
    #1;
    chk("mid_en",  enable, 0);
    chk("mid_res0", res, 0);
    chk("mid_src0", src, 0);
    chk("mid_ptr", rdy, 4'b0001);

    // 6. Stall fairness between channels 1 and 2
    i1 = 5'd11; i2 = 5'd12; setv(4'b0011);
    #1;  chk("fair_rdy1", rdy, 4'b0001);
    step(); setv(4'b0010);
    #1;
    chk("fair_res1", res, 11);
    chk("fair_src1", src, 0);
    chk("fair_stall_rdy", rdy, 4'b0000);
    for (int n = 0; n < 2; n++) begin
      step();
      chk("fair_stall_rdy", rdy, 4'b0000);
      chk("fair_stall_res", res, 11);
    end
    ack = 1'b1;
    #1;  chk("fair_rdy2", rdy, 4'b0010);
    step(); ack = 1'b0; setv(4'b0000);
    #1;
    chk("fair_res2", res, 12);
    chk("fair_src2", src, 1);
    chk("fair_en2",  enable, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
